rename_fl: RTL and testbench

RENAME_FL -- requirements
Module: rename_fl

---
 rtl/rename_fl_if.sv | 61 ++++++
 rtl/rename_fl.sv | 109 ++++++++++
 tb/tb_rename_fl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rename_fl_if.sv
// Rename request, renamed result, commit and free-count signals for rename_fl.
// The flush wire is present only when RENAME_FLUSH_EN is defined.
interface rename_fl_if #(
  parameter int NAREG = 32,
  parameter int NPREG = 64
);
    localparam int AW = $clog2(NAREG);
    localparam int PW = $clog2(NPREG);

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic [AW-1:0] in_rd;
    logic          in_rd_valid;

    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_prs1;
    logic [PW-1:0] out_prs2;
    logic [PW-1:0] out_prd;
    logic [PW-1:0] out_prd_old;
    logic          out_rd_valid;

    logic          commit_valid;
    logic [AW-1:0] commit_rd;
    logic          commit_rd_valid;
    logic [PW-1:0] commit_prd;

    logic [PW:0]   free_count;

`ifdef RENAME_FLUSH_EN
    logic          flush;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_valid, out_ready,
               commit_valid, commit_rd, commit_rd_valid, commit_prd, flush,
        input  in_ready, out_valid, out_prs1, out_prs2, out_prd, out_prd_old,
               out_rd_valid, free_count
    );
    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_valid, out_ready,
               commit_valid, commit_rd, commit_rd_valid, commit_prd, flush,
        output in_ready, out_valid, out_prs1, out_prs2, out_prd, out_prd_old,
               out_rd_valid, free_count
    );
`else
    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_valid, out_ready,
               commit_valid, commit_rd, commit_rd_valid, commit_prd,
        input  in_ready, out_valid, out_prs1, out_prs2, out_prd, out_prd_old,
               out_rd_valid, free_count
    );
    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_valid, out_ready,
               commit_valid, commit_rd, commit_rd_valid, commit_prd,
        output in_ready, out_valid, out_prs1, out_prs2, out_prd, out_prd_old,
               out_rd_valid, free_count
    );
`endif
endinterface

// File: rtl/rename_fl.sv
// Register rename stage: speculative/committed map tables plus a circular free list.
// Optional RENAME_FLUSH_EN restores the speculative map and head from committed state.
module rename_fl #(
  parameter int NAREG = 32,
  parameter int NPREG = 64
) (
    input logic        clk,
    input logic        rstn,
    rename_fl_if.slave bus
);
    localparam int AW    = $clog2(NAREG);
    localparam int PW    = $clog2(NPREG);
    localparam int NFREE = NPREG - NAREG;

    logic [PW-1:0] rmt  [NAREG];
    logic [PW-1:0] crmt [NAREG];
    logic [PW-1:0] fifo [NPREG];

    logic [PW:0]   head, tail, chead;
    logic [PW:0]   head_n, tail_n, chead_n;
    logic [PW:0]   free_cnt;

    logic          out_valid_q;
    logic [PW-1:0] prs1_q, prs2_q, prd_q, prd_old_q;
    logic          rd_valid_q;

    logic          alloc_req, rdy, accept, do_alloc, commit_do, restore;

    always_comb begin
        alloc_req = bus.in_rd_valid && (bus.in_rd != '0);
        commit_do = bus.commit_valid && bus.commit_rd_valid && (bus.commit_rd != '0);
`ifdef RENAME_FLUSH_EN
        restore   = bus.flush;
`else
        restore   = 1'b0;
`endif
        rdy       = rstn && (!out_valid_q || bus.out_ready)
                    && !(alloc_req && (free_cnt == '0)) && !restore;
        accept    = bus.in_valid && rdy;
        do_alloc  = accept && alloc_req;
        tail_n    = tail  + (PW+1)'(commit_do);
        chead_n   = chead + (PW+1)'(commit_do);
        head_n    = restore ? chead_n : head + (PW+1)'(do_alloc);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int a = 0; a < NAREG; a++) begin
                rmt[a]  <= PW'(a);
                crmt[a] <= PW'(a);
            end
            for (int i = 0; i < NPREG; i++)
                fifo[i] <= (i < NFREE) ? PW'(NAREG + i) : '0;
            head        <= '0;
            chead       <= '0;
            tail        <= (PW+1)'(NFREE);
            free_cnt    <= (PW+1)'(NFREE);
            out_valid_q <= 1'b0;
            prs1_q      <= '0;
            prs2_q      <= '0;
            prd_q       <= '0;
            prd_old_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            head     <= head_n;
            tail     <= tail_n;
            chead    <= chead_n;
            free_cnt <= tail_n - head_n;

            // Retirement frees the previous committed mapping of rd.
            if (commit_do) begin
                fifo[tail[PW-1:0]]  <= crmt[bus.commit_rd];
                crmt[bus.commit_rd] <= bus.commit_prd;
            end

            if (do_alloc)
                rmt[bus.in_rd] <= fifo[head[PW-1:0]];

            if (accept) begin
                out_valid_q <= 1'b1;
                prs1_q      <= rmt[bus.in_rs1];
                prs2_q      <= rmt[bus.in_rs2];
                prd_q       <= alloc_req ? fifo[head[PW-1:0]] : '0;
                prd_old_q   <= alloc_req ? rmt[bus.in_rd] : '0;
                rd_valid_q  <= alloc_req;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

`ifdef RENAME_FLUSH_EN
            // Restore sees the commit landing this same cycle.
            if (bus.flush) begin
                for (int a = 0; a < NAREG; a++)
                    rmt[a] <= (commit_do && (bus.commit_rd == AW'(a))) ? bus.commit_prd : crmt[a];
                out_valid_q <= 1'b0;
            end
`endif
        end
    end

    assign bus.in_ready     = rdy;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_prs1     = prs1_q;
    assign bus.out_prs2     = prs2_q;
    assign bus.out_prd      = prd_q;
    assign bus.out_prd_old  = prd_old_q;
    assign bus.out_rd_valid = rd_valid_q;
    assign bus.free_count   = free_cnt;
endmodule

// File: tb/tb_rename_fl.sv
// Directed bench for rename_fl with hand-computed expectations.
module tb_rename_fl;
    logic clk;
    logic rstn;
    int   ncmp;
    int   nerr;

    rename_fl_if #(.NAREG(32), .NPREG(64)) bus ();

    rename_fl #(.NAREG(32), .NPREG(64)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ren(input logic v, input int rd, input logic rdv, input int rs1, input int rs2);
        bus.in_valid    = v;
        bus.in_rd       = 5'(rd);
        bus.in_rd_valid = rdv;
        bus.in_rs1      = 5'(rs1);
        bus.in_rs2      = 5'(rs2);
    endtask

    task automatic cmt(input logic v, input int rd, input logic rdv, input int prd);
        bus.commit_valid    = v;
        bus.commit_rd       = 5'(rd);
        bus.commit_rd_valid = rdv;
        bus.commit_prd      = 6'(prd);
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        rstn = 1'b0;
        bus.out_ready = 1'b1;
        ren(1'b1, 5, 1'b1, 3, 0);
        cmt(1'b0, 0, 1'b0, 0);
`ifdef RENAME_FLUSH_EN
        bus.flush = 1'b0;
`endif
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_free_count", 32'(bus.free_count), 32);
        chk("rst_out_prd", 32'(bus.out_prd), 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("first_in_ready", 32'(bus.in_ready), 1);

        tick();
        chk("t1_out_valid", 32'(bus.out_valid), 1);
        chk("t1_prd", 32'(bus.out_prd), 32);
        chk("t1_prd_old", 32'(bus.out_prd_old), 5);
        chk("t1_prs1", 32'(bus.out_prs1), 3);
        chk("t1_prs2", 32'(bus.out_prs2), 0);
        chk("t1_rd_valid", 32'(bus.out_rd_valid), 1);
        chk("t1_free_count", 32'(bus.free_count), 31);
        ren(1'b1, 7, 1'b1, 5, 5);

        tick();
        chk("b2b_prd", 32'(bus.out_prd), 33);
        chk("b2b_prd_old", 32'(bus.out_prd_old), 7);
        chk("b2b_prs1", 32'(bus.out_prs1), 32);
        chk("b2b_prs2", 32'(bus.out_prs2), 32);
        chk("b2b_free_count", 32'(bus.free_count), 30);
        ren(1'b1, 0, 1'b1, 7, 0);

        tick();
        chk("rd0_rd_valid", 32'(bus.out_rd_valid), 0);
        chk("rd0_prd", 32'(bus.out_prd), 0);
        chk("rd0_prd_old", 32'(bus.out_prd_old), 0);
        chk("rd0_prs1", 32'(bus.out_prs1), 33);
        chk("rd0_free_count", 32'(bus.free_count), 30);
        ren(1'b0, 0, 1'b0, 0, 0);
        cmt(1'b1, 5, 1'b1, 32);

        tick();
        chk("drain_out_valid", 32'(bus.out_valid), 0);
        chk("commit_free_count", 32'(bus.free_count), 31);
        cmt(1'b1, 6, 1'b0, 40);

        tick();
        chk("commit_nord_free_count", 32'(bus.free_count), 31);
        cmt(1'b0, 0, 1'b0, 0);

        // Output stall: payload and allocation state must hold.
        bus.out_ready = 1'b0;
        ren(1'b1, 3, 1'b1, 7, 3);
        #1;
        chk("stall_pre_in_ready", 32'(bus.in_ready), 1);
        tick();
        chk("stall_prd", 32'(bus.out_prd), 34);
        chk("stall_prs2", 32'(bus.out_prs2), 3);
        ren(1'b1, 4, 1'b1, 3, 0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", 32'(bus.in_ready), 0);
            tick();
            chk("stall_hold_valid", 32'(bus.out_valid), 1);
            chk("stall_hold_prd", 32'(bus.out_prd), 34);
            chk("stall_hold_prs1", 32'(bus.out_prs1), 33);
            chk("stall_hold_free", 32'(bus.free_count), 30);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", 32'(bus.in_ready), 1);
        tick();
        chk("unstall_prd", 32'(bus.out_prd), 35);
        chk("unstall_prd_old", 32'(bus.out_prd_old), 4);
        chk("unstall_prs1", 32'(bus.out_prs1), 34);
        chk("unstall_free", 32'(bus.free_count), 29);

        // Asynchronous reset while a result is pending.
        ren(1'b0, 4, 1'b1, 0, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 0);
        chk("arst_free_count", 32'(bus.free_count), 32);
        chk("arst_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        rstn = 1'b1;
        ren(1'b1, 4, 1'b1, 5, 7);
        tick();
        chk("arst_prs1_identity", 32'(bus.out_prs1), 5);
        chk("arst_prs2_identity", 32'(bus.out_prs2), 7);
        chk("arst_prd", 32'(bus.out_prd), 32);
        chk("arst_prd_old", 32'(bus.out_prd_old), 4);

        // Exhaust the free list.
        ren(1'b0, 0, 1'b0, 0, 0);
        rstn = 1'b0;
        #1;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 32; k++) begin
            ren(1'b1, (k < 31) ? k + 1 : 1, 1'b1, 0, 0);
            tick();
        end
        chk("fill_prd", 32'(bus.out_prd), 63);
        chk("fill_prd_old", 32'(bus.out_prd_old), 32);
        chk("fill_free_count", 32'(bus.free_count), 0);
        ren(1'b1, 5, 1'b1, 0, 0);
        #1;
        chk("empty_in_ready", 32'(bus.in_ready), 0);
        ren(1'b1, 5, 1'b0, 1, 0);
        #1;
        chk("empty_nodest_in_ready", 32'(bus.in_ready), 1);
        tick();
        chk("empty_nodest_rd_valid", 32'(bus.out_rd_valid), 0);
        chk("empty_nodest_prs1", 32'(bus.out_prs1), 63);
        chk("empty_nodest_free", 32'(bus.free_count), 0);
        ren(1'b1, 5, 1'b1, 0, 0);
        cmt(1'b1, 1, 1'b1, 32);
        #1;
        chk("no_bypass_in_ready", 32'(bus.in_ready), 0);
        tick();
        cmt(1'b0, 0, 1'b0, 0);
        chk("freed_free_count", 32'(bus.free_count), 1);
        chk("freed_in_ready", 32'(bus.in_ready), 1);
        tick();
        chk("wrap_prd", 32'(bus.out_prd), 1);
        chk("wrap_prd_old", 32'(bus.out_prd_old), 36);
        chk("wrap_free_count", 32'(bus.free_count), 0);

`ifdef RENAME_FLUSH_EN
        ren(1'b0, 0, 1'b0, 0, 0);
        rstn = 1'b0;
        #1;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            ren(1'b1, k, 1'b1, 0, 0);
            tick();
        end
        ren(1'b1, 6, 1'b1, 0, 0);
        cmt(1'b1, 1, 1'b1, 32);
        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 0);
        tick();
        bus.flush = 1'b0;
        cmt(1'b0, 0, 1'b0, 0);
        chk("flush_out_valid", 32'(bus.out_valid), 0);
        chk("flush_free_count", 32'(bus.free_count), 32);
        ren(1'b1, 6, 1'b1, 1, 2);
        tick();
        chk("flush_prs1", 32'(bus.out_prs1), 32);
        chk("flush_prs2", 32'(bus.out_prs2), 2);
        chk("flush_prd", 32'(bus.out_prd), 33);
        chk("flush_prd_old", 32'(bus.out_prd_old), 6);
`endif

        ren(1'b0, 0, 1'b0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
